mem_bank: RTL

- Parametrised single-port word memory. Successor to the fixed 16 KiB testbench memory.
- Sits on the top-level memory bus (addr/write_en/data) of generated designs, in simulation benches and FPGA builds.
- Adds over the fixed memory: configurable width and depth, byte-lane write strobes, a req/ready/rvalid handshake with pipelined read latency, an out-of-range error flag, and a hardware clear sweep after reset.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_bank_rd_pipe.sv | 78 +++++++
 rtl/mem_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and parameter checks for mem_bank
//
// Purpose: FSM state encoding, byte-offset shift helper and the legal-range
//          checks used by elaboration-time assertions in mem_bank.
// Ports:   none (package).

package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    // Number of low address bits that select a byte inside one word.
    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic bit read_latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

    function automatic bit data_width_ok(input int data_width);
        return (data_width >= 8) && (data_width <= 128) && ((data_width % 8) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_bank_rd_pipe.sv
// rtl/mem_bank_rd_pipe.sv - read-return delay line for mem_bank
//
// Purpose: delays {valid, err, data} of an accepted read by STAGES cycles.
//          Data registers only load when their valid input is set, so the
//          final data output holds its last returned value between reads.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low clear of all stages
//   valid_i  in   read accepted this cycle
//   err_i    in   accepted read was out of range
//   data_i   in   word read at acceptance
//   valid_o  out  delayed valid
//   err_o    out  delayed error
//   data_o   out  delayed data, held while valid_o is low

module mem_bank_rd_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic                  err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  v0_q;
    logic                  e0_q;
    logic [DATA_WIDTH-1:0] d0_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v0_q <= 1'b0;
            e0_q <= 1'b0;
            d0_q <= '0;
        end else begin
            v0_q <= valid_i;
            e0_q <= err_i;
            if (valid_i) begin
                d0_q <= data_i;
            end
        end
    end

    if (STAGES == 2) begin : g_two
        logic                  v1_q;
        logic                  e1_q;
        logic [DATA_WIDTH-1:0] d1_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                v1_q <= 1'b0;
                e1_q <= 1'b0;
                d1_q <= '0;
            end else begin
                v1_q <= v0_q;
                e1_q <= e0_q;
                if (v0_q) begin
                    d1_q <= d0_q;
                end
            end
        end

        assign valid_o = v1_q;
        assign err_o   = e1_q;
        assign data_o  = d1_q;
    end else begin : g_one
        assign valid_o = v0_q;
        assign err_o   = e0_q;
        assign data_o  = d0_q;
    end

endmodule

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - parametrised single-port word memory with byte strobes
//
// Purpose: word-addressed storage on a byte-addressed req/ready bus with
//          pipelined reads, out-of-range error pulses and an optional
//          zero-fill sweep after reset.
// Ports:
//   clk_i        in   clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   req_i        in   request valid
//   write_en_i   in   1 = write, 0 = read
//   addr_i       in   byte address
//   wstrb_i      in   byte-lane write enables
//   wdata_i      in   write data
//   ready_o      out  request accepted when req_i && ready_o
//   rvalid_o     out  one-cycle pulse per accepted read
//   rdata_o      out  read data, held while rvalid_o is low
//   err_o        out  one-cycle pulse for an out-of-range access
//   init_done_o  out  high once the clear sweep is complete

module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_i,
    input  logic                    write_en_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    ready_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    init_done_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int SHIFT     = byte_shift(DATA_WIDTH);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int TOP       = SHIFT + IDX_W;
    // Widened address so the above-index slice exists even for narrow buses.
    localparam int EXT_W     = (ADDR_WIDTH > TOP) ? ADDR_WIDTH : TOP + 1;

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $fatal(1, "mem_bank: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
        $fatal(1, "mem_bank: READ_LATENCY must be 1 or 2");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $fatal(1, "mem_bank: DEPTH must be a power of two, at least 2");
    end

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [EXT_W-1:0] addr_ext;
    logic [IDX_W-1:0] idx;
    logic             oor;

    assign addr_ext = EXT_W'(addr_i);
    assign idx      = addr_ext[SHIFT +: IDX_W];
    assign oor      = |(addr_ext >> TOP);

    // ---------------------------------------------------------------
    // FSM: INIT sweeps zeros through every word, RUN serves requests
    // ---------------------------------------------------------------
    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             clr_we;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        clr_we  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we  = 1'b1;
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign ready_o     = (state_q == ST_RUN);
    assign init_done_o = (state_q == ST_RUN);

    // ---------------------------------------------------------------
    // Request acceptance
    // ---------------------------------------------------------------
    logic acc;
    logic wr_hit;
    logic rd_acc;

    assign acc    = req_i && ready_o;
    assign wr_hit = acc && write_en_i && !oor;
    assign rd_acc = acc && !write_en_i;

    // ---------------------------------------------------------------
    // Storage: sweep write has priority; it never overlaps RUN traffic
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[sweep_q] <= '0;
        end else if (wr_hit) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Write errors report one cycle after acceptance, independent of latency.
    logic wr_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= acc && write_en_i && oor;
        end
    end

    // ---------------------------------------------------------------
    // Read return path; data sampled before the accepting edge updates
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;

    assign rd_word = oor ? '0 : mem_q[idx];
    assign rd_err  = rd_acc && oor;

    logic pipe_err;

    mem_bank_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READ_LATENCY)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (rd_acc),
        .err_i   (rd_err),
        .data_i  (rd_word),
        .valid_o (rvalid_o),
        .err_o   (pipe_err),
        .data_o  (rdata_o)
    );

    assign err_o = pipe_err || wr_err_q;

endmodule
